// File: rtl/axi_lite_mem_bridge.sv
// axi_lite_mem_bridge
//   AXI4-Lite slave that converts AXI read/write transactions into a single-port
//   memory strobe interface (block-RAM register/memory bank behind it). One
//   outstanding transaction at a time; every response is OKAY.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   s_axi_aw*             write address channel (awaddr, awvalid, awready)
//   s_axi_w*              write data channel (wdata, wstrb, wvalid, wready)
//   s_axi_b*              write response channel (bresp = 00, bvalid, bready)
//   s_axi_ar*             read address channel (araddr, arvalid, arready)
//   s_axi_r*              read data channel (rdata, rresp = 00, rvalid, rready)
//   mem_addr              word address shared by reads and writes
//   mem_wen/wstrb/wdata   one-cycle write strobe with byte enables and data
//   mem_ren               one-cycle read strobe
//   mem_rdata             memory read data, valid the cycle after mem_ren
module axi_lite_mem_bridge #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int OPT_MEM_ADDR_BITS  = 7
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // write address
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    // write data
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    // write response
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    // read address
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    // read data
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    // memory side
    output logic [OPT_MEM_ADDR_BITS:0]        mem_addr,
    output logic                              mem_wen,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   mem_wstrb,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     mem_wdata,
    output logic                              mem_ren,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mem_rdata
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int SW       = C_S_AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH / 8);
    localparam int MEM_AW   = OPT_MEM_ADDR_BITS + 1;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WR_COLLECT = 3'd1;
    localparam logic [2:0] WR_MEM     = 3'd2;
    localparam logic [2:0] WR_RESP    = 3'd3;
    localparam logic [2:0] RD_MEM     = 3'd4;
    localparam logic [2:0] RD_WAIT    = 3'd5;
    localparam logic [2:0] RD_RESP    = 3'd6;

    logic [2:0]        state_q, state_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              arready_q, arready_d;
    logic              bvalid_q, bvalid_d;
    logic              rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic              wen_q, wen_d;
    logic              ren_q, ren_d;

    logic aw_hs, w_hs, ar_hs;

    // Byte-offset and above-memory address bits are deliberately ignored (wrap-around).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    assign aw_hs = s_axi_awvalid && awready_q;
    assign w_hs  = s_axi_wvalid && wready_q;
    // Writes win: any write activity in the same cycle suppresses the read accept.
    assign ar_hs = s_axi_arvalid && arready_q && !s_axi_awvalid && !s_axi_wvalid;

    always_comb begin
        state_d   = state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        arready_d = arready_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wen_d     = 1'b0;
        ren_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // Readys come up here after reset and stay up while idle.
                awready_d = 1'b1;
                wready_d  = 1'b1;
                arready_d = 1'b1;
                if (aw_hs) begin
                    addr_d    = s_axi_awaddr[ADDR_LSB +: MEM_AW];
                    awready_d = 1'b0;
                end
                if (w_hs) begin
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                    wready_d = 1'b0;
                end
                if (s_axi_awvalid || s_axi_wvalid) begin
                    arready_d = 1'b0;
                end
                if (aw_hs && w_hs) begin
                    wen_d   = 1'b1;
                    state_d = WR_MEM;
                end else if (aw_hs || w_hs) begin
                    state_d = WR_COLLECT;
                end else if (ar_hs) begin
                    addr_d    = s_axi_araddr[ADDR_LSB +: MEM_AW];
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    arready_d = 1'b0;
                    ren_d     = 1'b1;
                    state_d   = RD_MEM;
                end
            end
            WR_COLLECT: begin
                if (aw_hs) begin
                    addr_d    = s_axi_awaddr[ADDR_LSB +: MEM_AW];
                    awready_d = 1'b0;
                end
                if (w_hs) begin
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                    wready_d = 1'b0;
                end
                // A low ready means that channel was already captured.
                if ((aw_hs || !awready_q) && (w_hs || !wready_q)) begin
                    wen_d   = 1'b1;
                    state_d = WR_MEM;
                end
            end
            WR_MEM: begin
                bvalid_d = 1'b1;
                state_d  = WR_RESP;
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    arready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            RD_MEM: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                rdata_d  = mem_rdata;
                rvalid_d = 1'b1;
                state_d  = RD_RESP;
            end
            RD_RESP: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    arready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wen_q     <= wen_d;
            ren_q     <= ren_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_arready = arready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wstrb     = wstrb_q;
    assign mem_wdata     = wdata_q;
    assign mem_ren       = ren_q;

endmodule

// File: tb/tb_axi_lite_mem_bridge.sv
module tb_axi_lite_mem_bridge;

    logic        clk;
    logic        rst_n;
    logic [11:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [11:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [7:0]  mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ren;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    axi_lite_mem_bridge #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(12),
        .OPT_MEM_ADDR_BITS (7)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .mem_addr     (mem_addr),
        .mem_wen      (mem_wen),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_ren      (mem_ren),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block-RAM model: byte-enabled write, registered read.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
        if (mem_ren) mem_rdata <= mem[mem_addr];
    end

    // Event counters sampled on the active edge (pre-update values).
    int wen_cnt = 0;
    int ren_cnt = 0;
    int bhs_cnt = 0;
    int bvalid_cyc = 0;
    int rvalid_cyc = 0;
    bit overlap = 1'b0;
    always @(posedge clk) begin
        if (mem_wen) wen_cnt <= wen_cnt + 1;
        if (mem_ren) ren_cnt <= ren_cnt + 1;
        if (s_axi_bvalid && s_axi_bready) bhs_cnt <= bhs_cnt + 1;
        if (s_axi_bvalid) bvalid_cyc <= bvalid_cyc + 1;
        if (s_axi_rvalid) rvalid_cyc <= rvalid_cyc + 1;
        if (mem_wen && mem_ren) overlap <= 1'b1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Full write from IDLE; ok=0 if no bvalid arrives within the budget.
    task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output bit ok);
        ok = 1'b0;
        s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        s_axi_bready = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_axi_bvalid) begin ok = 1'b1; break; end
        end
        tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] addr, output logic [31:0] data, output bit ok);
        ok = 1'b0; data = '0;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_axi_rvalid) begin ok = 1'b1; data = s_axi_rdata; break; end
        end
        tick();
        s_axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
             mem_wen, mem_ren} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b%b%b%b%b%b%b want 0000000", s_axi_awready,
                     s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, mem_wen, mem_ren);
        end
        n_checks++;
        if ({mem_addr, mem_wdata, mem_wstrb, s_axi_rdata} !== 76'h0) begin
            n_fail++;
            $display("FAIL reset_data: addr %h wdata %h wstrb %h rdata %h want all 0",
                     mem_addr, mem_wdata, mem_wstrb, s_axi_rdata);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_idle_readys: got %b%b%b want 111",
                     s_axi_awready, s_axi_wready, s_axi_arready);
        end
    endtask

    // AW and W in the same cycle to 0x010.
    task automatic test_write_same_cycle();
        int w0, b0;
        w0 = wen_cnt; b0 = bhs_cnt;
        s_axi_awaddr = 12'h010; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        n_checks++;
        if ({mem_wen, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 8'd4, 32'hDEADBEEF, 4'hF}) begin
            n_fail++;
            $display("FAIL wr1_mem: wen %b addr %0d wdata %h wstrb %h want 1 4 deadbeef f",
                     mem_wen, mem_addr, mem_wdata, mem_wstrb);
        end
        n_checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid} !== 4'b0) begin
            n_fail++;
            $display("FAIL wr1_busy: readys %b%b%b bvalid %b want 0000", s_axi_awready,
                     s_axi_wready, s_axi_arready, s_axi_bvalid);
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        tick();
        n_checks++;
        if ({mem_wen, s_axi_bvalid, s_axi_bresp} !== 4'b0100) begin
            n_fail++;
            $display("FAIL wr1_resp: wen %b bvalid %b bresp %b want 0 1 00",
                     mem_wen, s_axi_bvalid, s_axi_bresp);
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        n_checks++;
        if ({s_axi_bvalid, s_axi_awready} !== 2'b01) begin
            n_fail++;
            $display("FAIL wr1_done: bvalid %b awready %b want 0 1", s_axi_bvalid, s_axi_awready);
        end
        n_checks++;
        if ((wen_cnt - w0) != 1 || (bhs_cnt - b0) != 1) begin
            n_fail++;
            $display("FAIL wr1_counts: wen pulses %0d bresp handshakes %0d want 1 1",
                     wen_cnt - w0, bhs_cnt - b0);
        end
    endtask

    // W arrives three cycles ahead of AW (0x040).
    task automatic test_w_before_aw();
        int w0, b0;
        w0 = wen_cnt; b0 = bhs_cnt;
        s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        n_checks++;
        if ({s_axi_wready, s_axi_awready, s_axi_arready, mem_wen} !== 4'b0100) begin
            n_fail++;
            $display("FAIL wfirst_collect: wready %b awready %b arready %b wen %b want 0 1 0 0",
                     s_axi_wready, s_axi_awready, s_axi_arready, mem_wen);
        end
        repeat (2) tick();
        n_checks++;
        if ((wen_cnt - w0) != 0 || s_axi_wready !== 1'b0) begin
            n_fail++;
            $display("FAIL wfirst_wait: wen pulses %0d wready %b want 0 0",
                     wen_cnt - w0, s_axi_wready);
        end
        s_axi_awaddr = 12'h040; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        n_checks++;
        if ({mem_wen, mem_addr, mem_wdata, s_axi_awready} !== {1'b1, 8'd16, 32'h12345678, 1'b0})
        begin
            n_fail++;
            $display("FAIL wfirst_mem: wen %b addr %0d wdata %h awready %b want 1 16 12345678 0",
                     mem_wen, mem_addr, mem_wdata, s_axi_awready);
        end
        s_axi_bready = 1'b1;
        tick();
        n_checks++;
        if (s_axi_bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL wfirst_bvalid: got %b want 1", s_axi_bvalid);
        end
        tick();
        s_axi_bready = 1'b0;
        n_checks++;
        if ({s_axi_bvalid, s_axi_wready} !== 2'b01 || (wen_cnt - w0) != 1 || (bhs_cnt - b0) != 1)
        begin
            n_fail++;
            $display("FAIL wfirst_done: bvalid %b wready %b wen %0d bhs %0d want 0 1 1 1",
                     s_axi_bvalid, s_axi_wready, wen_cnt - w0, bhs_cnt - b0);
        end
    endtask

    // Read with rready held low for five cycles.
    task automatic test_read_stall();
        bit ok;
        int r0;
        do_write(12'h020, 32'hA5A5A5A5, 4'hF, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_prewrite: bvalid seen %b want 1", ok);
        end
        r0 = ren_cnt;
        s_axi_araddr = 12'h020; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        tick();
        s_axi_arvalid = 1'b0;
        n_checks++;
        if ({mem_ren, mem_addr, s_axi_arready, mem_wen} !== {1'b1, 8'd8, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_ren: ren %b addr %0d arready %b wen %b want 1 8 0 0",
                     mem_ren, mem_addr, s_axi_arready, mem_wen);
        end
        tick();
        n_checks++;
        if ({mem_ren, s_axi_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_wait: ren %b rvalid %b want 0 0", mem_ren, s_axi_rvalid);
        end
        tick();
        n_checks++;
        if ({s_axi_rvalid, s_axi_rdata, s_axi_rresp} !== {1'b1, 32'hA5A5A5A5, 2'b00}) begin
            n_fail++;
            $display("FAIL rd_first: rvalid %b rdata %h rresp %b want 1 a5a5a5a5 00",
                     s_axi_rvalid, s_axi_rdata, s_axi_rresp);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({s_axi_rvalid, s_axi_rdata} !== {1'b1, 32'hA5A5A5A5}) begin
                n_fail++;
                $display("FAIL rd_hold[%0d]: rvalid %b rdata %h want 1 a5a5a5a5",
                         i, s_axi_rvalid, s_axi_rdata);
            end
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        n_checks++;
        if (s_axi_rvalid !== 1'b0 || (ren_cnt - r0) != 1) begin
            n_fail++;
            $display("FAIL rd_done: rvalid %b ren pulses %0d want 0 1", s_axi_rvalid, ren_cnt - r0);
        end
    endtask

    // AW, W and AR together: write goes first, read returns the new data.
    task automatic test_back_to_back();
        int r0;
        r0 = ren_cnt;
        s_axi_awaddr = 12'h030; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        s_axi_araddr = 12'h030; s_axi_arvalid = 1'b1;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n_checks++;
        if ({mem_wen, mem_ren, s_axi_arready} !== 3'b100) begin
            n_fail++;
            $display("FAIL prio_write_first: wen %b ren %b arready %b want 1 0 0",
                     mem_wen, mem_ren, s_axi_arready);
        end
        tick();
        n_checks++;
        if (s_axi_bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_bvalid: got %b want 1", s_axi_bvalid);
        end
        tick();
        n_checks++;
        if ({s_axi_arready, s_axi_bvalid} !== 2'b10 || ren_cnt != r0) begin
            n_fail++;
            $display("FAIL prio_ar_pending: arready %b bvalid %b ren pulses %0d want 1 0 0",
                     s_axi_arready, s_axi_bvalid, ren_cnt - r0);
        end
        tick();
        s_axi_arvalid = 1'b0;
        s_axi_bready = 1'b0;
        n_checks++;
        if ({mem_ren, mem_addr} !== {1'b1, 8'd12}) begin
            n_fail++;
            $display("FAIL prio_ren: ren %b addr %0d want 1 12", mem_ren, mem_addr);
        end
        repeat (2) tick();
        n_checks++;
        if ({s_axi_rvalid, s_axi_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            n_fail++;
            $display("FAIL prio_rdata: rvalid %b rdata %h want 1 cafef00d",
                     s_axi_rvalid, s_axi_rdata);
        end
        tick();
        s_axi_rready = 1'b0;
        n_checks++;
        if (s_axi_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_rdone: rvalid %b want 0", s_axi_rvalid);
        end
    endtask

    // 0xC04 has bits above the 8-bit word index set and wraps onto word 1.
    task automatic test_addr_wrap();
        bit ok;
        logic [31:0] d;
        int w0;
        do_write(12'h004, 32'h11223344, 4'hF, ok);
        s_axi_awaddr = 12'hC04; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hFFFFABFF; s_axi_wstrb = 4'b0010; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n_checks++;
        if ({mem_wen, mem_addr, mem_wstrb} !== {1'b1, 8'd1, 4'b0010}) begin
            n_fail++;
            $display("FAIL wrap_mem: wen %b addr %0d wstrb %b want 1 1 0010",
                     mem_wen, mem_addr, mem_wstrb);
        end
        s_axi_bready = 1'b1;
        repeat (2) tick();
        s_axi_bready = 1'b0;
        do_read(12'h007, d, ok);
        n_checks++;
        if (ok !== 1'b1 || d !== 32'h1122AB44) begin
            n_fail++;
            $display("FAIL wrap_readback: ok %b rdata %h want 1 1122ab44", ok, d);
        end
        // Zero strobe still pulses mem_wen but changes nothing.
        w0 = wen_cnt;
        do_write(12'h004, 32'hFFFFFFFF, 4'h0, ok);
        n_checks++;
        if (ok !== 1'b1 || (wen_cnt - w0) != 1) begin
            n_fail++;
            $display("FAIL zero_strb_pulse: ok %b wen pulses %0d want 1 1", ok, wen_cnt - w0);
        end
        do_read(12'h004, d, ok);
        n_checks++;
        if (ok !== 1'b1 || d !== 32'h1122AB44) begin
            n_fail++;
            $display("FAIL zero_strb_data: ok %b rdata %h want 1 1122ab44", ok, d);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [31:0] d;
        int r0, rv0, w0, bv0;
        // Reset during RD_WAIT.
        s_axi_araddr = 12'h020; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({s_axi_rvalid, s_axi_rdata} !== 33'h0) begin
            n_fail++;
            $display("FAIL rst_rd_clear: rvalid %b rdata %h want 0 0", s_axi_rvalid, s_axi_rdata);
        end
        r0 = ren_cnt; rv0 = rvalid_cyc;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        s_axi_rready = 1'b0;
        n_checks++;
        if (rvalid_cyc != rv0 || ren_cnt != r0 ||
            {s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            n_fail++;
            $display("FAIL rst_rd_quiet: rvalid cycles %0d ren pulses %0d readys %b%b%b want 0 0 111",
                     rvalid_cyc - rv0, ren_cnt - r0, s_axi_awready, s_axi_wready, s_axi_arready);
        end
        // Reset during WR_COLLECT (AW captured, W never sent).
        w0 = wen_cnt; bv0 = bvalid_cyc;
        s_axi_awaddr = 12'h050; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        n_checks++;
        if ({s_axi_awready, s_axi_wready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_wr_collect: awready %b wready %b want 0 1",
                     s_axi_awready, s_axi_wready);
        end
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (wen_cnt != w0 || bvalid_cyc != bv0) begin
            n_fail++;
            $display("FAIL rst_wr_quiet: wen pulses %0d bvalid cycles %0d want 0 0",
                     wen_cnt - w0, bvalid_cyc - bv0);
        end
        do_write(12'h050, 32'h55AA55AA, 4'hF, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_next_write: bvalid seen %b want 1", ok);
        end
        do_read(12'h050, d, ok);
        n_checks++;
        if (ok !== 1'b1 || d !== 32'h55AA55AA) begin
            n_fail++;
            $display("FAIL rst_next_read: ok %b rdata %h want 1 55aa55aa", ok, d);
        end
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_read_stall();
        test_back_to_back();
        test_addr_wrap();
        test_reset_mid();
        n_checks++;
        if (overlap !== 1'b0) begin
            n_fail++;
            $display("FAIL wen_ren_overlap: got %b want 0", overlap);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
